// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: shares one serializer between the pattern generator and the message encoder.
// Optional macro SB_ARB_RR_EN selects round-robin grants; otherwise messages have fixed priority.
module sb_tx_arbiter #(
    parameter int GAP_CYCLES   = 4,
    parameter int DONE_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_arb_en,
    input  logic        i_pat_valid,
    input  logic [63:0] i_pat_data,
    output logic        o_pat_ser_done,
    output logic [7:0]  o_pat_drop_cnt,
    input  logic        i_msg_valid,
    output logic        o_msg_ready,
    input  logic [63:0] i_msg_hdr,
    input  logic [63:0] i_msg_data,
    input  logic        i_msg_has_data,
    output logic        o_msg_done,
    output logic [63:0] o_ser_data,
    output logic        o_ser_valid,
    input  logic        i_ser_done,
    output logic        o_ser_timeout
);

    typedef enum logic [2:0] {IDLE, WAIT_PAT, WAIT_HDR, WAIT_DATA, GAP} state_e;

    localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]      TMO_LAST = 8'(DONE_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          pat_full_q, pat_full_d;
    logic          pat_granted_q, pat_granted_d;
    logic [63:0]   pat_data_q, pat_data_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          msg_full_q, msg_full_d;
    logic [63:0]   msg_hdr_q, msg_hdr_d;
    logic [63:0]   msg_data_q, msg_data_d;
    logic          msg_has_data_q, msg_has_data_d;
    logic          ser_valid_q, ser_valid_d;
    logic [63:0]   ser_data_q, ser_data_d;
    logic          pat_done_q, pat_done_d;
    logic          msg_done_q, msg_done_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`ifdef SB_ARB_RR_EN
    logic          last_pat_q, last_pat_d;
`endif

    logic   grant_msg, grant_pat, pkt_end, expired;
    state_e after_pkt;

    always_comb begin
        state_d        = state_q;
        pat_full_d     = pat_full_q;
        pat_granted_d  = pat_granted_q;
        pat_data_d     = pat_data_q;
        drop_cnt_d     = drop_cnt_q;
        msg_full_d     = msg_full_q;
        msg_hdr_d      = msg_hdr_q;
        msg_data_d     = msg_data_q;
        msg_has_data_d = msg_has_data_q;
        ser_valid_d    = 1'b0;
        ser_data_d     = ser_data_q;
        pat_done_d     = 1'b0;
        msg_done_d     = 1'b0;
        tmo_d          = 1'b0;
        tmo_cnt_d      = tmo_cnt_q;
        gap_cnt_d      = gap_cnt_q;
`ifdef SB_ARB_RR_EN
        last_pat_d     = last_pat_q;
`endif
        grant_msg      = 1'b0;
        grant_pat      = 1'b0;
        pkt_end        = 1'b0;
        after_pkt      = (GAP_CYCLES == 0) ? IDLE : GAP;
        // A done pulse in the expiry cycle still completes the beat.
        expired        = (tmo_cnt_q == TMO_LAST) && !i_ser_done;

        case (state_q)
            IDLE: begin
                if (i_arb_en) begin
`ifdef SB_ARB_RR_EN
                    if (msg_full_q && (!pat_full_q || last_pat_q)) grant_msg = 1'b1;
                    else if (pat_full_q)                          grant_pat = 1'b1;
`else
                    if (msg_full_q)      grant_msg = 1'b1;
                    else if (pat_full_q) grant_pat = 1'b1;
`endif
                end
            end
            WAIT_PAT: begin
                if (i_ser_done) begin
                    pat_done_d = 1'b1;
                    pkt_end    = 1'b1;
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    pkt_end = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            WAIT_HDR: begin
                if (i_ser_done) begin
                    if (msg_has_data_q) begin
                        ser_valid_d = 1'b1;
                        ser_data_d  = msg_data_q;
                        tmo_cnt_d   = 8'd0;
                        state_d     = WAIT_DATA;
                    end else begin
                        msg_done_d = 1'b1;
                        pkt_end    = 1'b1;
                    end
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    pkt_end = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            WAIT_DATA: begin
                if (i_ser_done) begin
                    msg_done_d = 1'b1;
                    pkt_end    = 1'b1;
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    pkt_end = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else                       gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (grant_msg) begin
            ser_valid_d = 1'b1;
            ser_data_d  = msg_hdr_q;
            tmo_cnt_d   = 8'd0;
            state_d     = WAIT_HDR;
        end
        if (grant_pat) begin
            ser_valid_d = 1'b1;
            ser_data_d  = pat_data_q;
            tmo_cnt_d   = 8'd0;
            state_d     = WAIT_PAT;
        end
        if (pkt_end) begin
            state_d   = after_pkt;
            gap_cnt_d = '0;
`ifdef SB_ARB_RR_EN
            last_pat_d = (state_q == WAIT_PAT);
`endif
        end

        if (i_msg_valid && !msg_full_q) begin
            msg_full_d     = 1'b1;
            msg_hdr_d      = i_msg_hdr;
            msg_data_d     = i_msg_data;
            msg_has_data_d = i_msg_has_data;
        end
        if (pkt_end && (state_q == WAIT_HDR || state_q == WAIT_DATA)) msg_full_d = 1'b0;

        // pat_granted marks the buffered word as the one on the wire, so a reload
        // during flight survives the completion of the old word.
        if (i_pat_valid) begin
            pat_data_d    = i_pat_data;
            pat_full_d    = 1'b1;
            pat_granted_d = 1'b0;
            if (pat_full_q && !pat_granted_q && !grant_pat && drop_cnt_q != 8'hFF)
                drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (grant_pat) begin
            pat_granted_d = 1'b1;
        end
        if (pkt_end && state_q == WAIT_PAT && pat_granted_q && !i_pat_valid) begin
            pat_full_d    = 1'b0;
            pat_granted_d = 1'b0;
        end
        if (!i_arb_en && state_q != WAIT_PAT) begin
            pat_full_d    = 1'b0;
            pat_granted_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            pat_full_q     <= 1'b0;
            pat_granted_q  <= 1'b0;
            pat_data_q     <= '0;
            drop_cnt_q     <= '0;
            msg_full_q     <= 1'b0;
            msg_hdr_q      <= '0;
            msg_data_q     <= '0;
            msg_has_data_q <= 1'b0;
            ser_valid_q    <= 1'b0;
            ser_data_q     <= '0;
            pat_done_q     <= 1'b0;
            msg_done_q     <= 1'b0;
            tmo_q          <= 1'b0;
            tmo_cnt_q      <= '0;
            gap_cnt_q      <= '0;
`ifdef SB_ARB_RR_EN
            last_pat_q     <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            pat_full_q     <= pat_full_d;
            pat_granted_q  <= pat_granted_d;
            pat_data_q     <= pat_data_d;
            drop_cnt_q     <= drop_cnt_d;
            msg_full_q     <= msg_full_d;
            msg_hdr_q      <= msg_hdr_d;
            msg_data_q     <= msg_data_d;
            msg_has_data_q <= msg_has_data_d;
            ser_valid_q    <= ser_valid_d;
            ser_data_q     <= ser_data_d;
            pat_done_q     <= pat_done_d;
            msg_done_q     <= msg_done_d;
            tmo_q          <= tmo_d;
            tmo_cnt_q      <= tmo_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
`ifdef SB_ARB_RR_EN
            last_pat_q     <= last_pat_d;
`endif
        end
    end

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign o_msg_ready    = i_rst_n && !msg_full_q;
    assign o_ser_valid    = ser_valid_q;
    assign o_ser_data     = ser_data_q;
    assign o_pat_ser_done = pat_done_q;
    assign o_msg_done     = msg_done_q;
    assign o_ser_timeout  = tmo_q;
    assign o_pat_drop_cnt = drop_cnt_q;

endmodule

// File: doc/sb_tx_arbiter.md
Name: sb_tx_arbiter

Overview:
Shares the single sideband serializer between the sideband pattern generator and the sideband message encoder.
- Captures pattern words (one-cycle valid pulses) and message packets (header plus optional data beat).
- Grants one source at a time, issues words to the serializer and paces on its done pulse.
- Inserts a programmable idle gap between packets.
- Returns a per-source completion pulse so the pattern generator keeps its serializer pacing.

Parameters:
GAP_CYCLES, 4, idle cycles inserted after each completed packet (0 = no gap state)
DONE_TIMEOUT, 255, max cycles waiting for i_ser_done per beat before abort (8-bit counter)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; synchronous, active-low
i_arb_en  in  1  arbitration enable; low = no new grants, pattern buffer flushed
i_pat_valid  in  1  pattern word strobe (single cycle)
i_pat_data  in  64  pattern word
o_pat_ser_done  out  1  one-cycle pulse: granted pattern word fully serialized
o_pat_drop_cnt  out  8  saturating count of pattern words overwritten before grant
i_msg_valid  in  1  message packet valid
o_msg_ready  out  1  message capture ready (= !msg_full, combinational)
i_msg_hdr  in  64  message header
i_msg_data  in  64  message data beat
i_msg_has_data  in  1  packet carries data beat after header
o_msg_done  out  1  one-cycle pulse: message packet fully serialized
o_ser_data  out  64  word to serializer
o_ser_valid  out  1  one-cycle load strobe to serializer
i_ser_done  in  1  serializer finished current word (pulse)
o_ser_timeout  out  1  one-cycle pulse: beat aborted on timeout

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - All outputs 0; o_ser_data 0.
  - Buffers empty; state IDLE; counters 0; round-robin pointer = pattern-last.
  - Reset mid-packet drops everything; no done pulses are generated.
- Pattern buffer (1 entry):
  - On i_pat_valid, load i_pat_data and set pat_full.
  - If already full and not yet granted, overwrite and increment o_pat_drop_cnt (saturates at 255).
  - i_arb_en low clears pat_full, except while a pattern is in flight.
- Message buffer (1 packet):
  - Captures hdr, data and has_data when i_msg_valid && o_msg_ready.
  - msg_full clears in the cycle the final beat's i_ser_done arrives, or on timeout abort. o_msg_ready is high the next cycle.
- States: IDLE, WAIT_PAT, WAIT_HDR, WAIT_DATA, GAP.
- IDLE:
  - If i_arb_en and any buffer is full, grant per priority.
  - o_ser_valid=1 with o_ser_data driven the next cycle, for exactly one cycle.
  - Move to WAIT_PAT or WAIT_HDR.
  - Fixed priority: message over pattern.
- WAIT_HDR on i_ser_done:
  - has_data=1: o_ser_valid with data beat next cycle -> WAIT_DATA.
  - has_data=0: o_msg_done pulse next cycle -> GAP.
- WAIT_DATA on i_ser_done: o_msg_done pulse next cycle -> GAP.
- WAIT_PAT on i_ser_done: o_pat_ser_done pulse next cycle; clear pat_full unless reloaded in the same cycle -> GAP.
- GAP:
  - Count GAP_CYCLES cycles, then IDLE.
  - If GAP_CYCLES=0, WAIT states go directly to IDLE.
- Latency:
  - Buffered request to o_ser_valid: 1 cycle from IDLE.
  - Done to next packet: GAP_CYCLES+2 cycles.
- Packets are atomic; a header and its data are never separated by a pattern word.
- Timeout:
  - In any WAIT state the counter resets on each o_ser_valid.
  - Reaching DONE_TIMEOUT without i_ser_done: o_ser_timeout pulse; drop the granted packet or pattern; no done pulse; -> GAP.
- i_ser_done in IDLE or GAP is ignored.
- i_ser_done coinciding with timeout expiry: done wins.
- i_arb_en low mid-packet: in-flight packet completes normally; no new grant.

Optional Feature:
SB_ARB_RR_EN.
- Defined: round-robin grant between pattern and message. The pointer flips after each completed or aborted grant. After reset, message is served first when both are pending.
- Undefined: fixed priority, message over pattern.

Test Plan:
- Pattern only, GAP_CYCLES=4: i_pat_valid with data {32{2'b10}}, i_ser_done 10 cycles after o_ser_valid -> o_ser_data=AAAA_AAAA_AAAA_AAAA, o_pat_ser_done 1 cycle after done, next grant at earliest 6 cycles after done.
- Message with data: hdr=0x1111…, data=0x2222…, has_data=1 -> two o_ser_valid beats in order; o_msg_ready low until final done; o_msg_done exactly once.
- Both pending, fixed priority: message granted first, pattern next; no pattern between hdr and data. With SB_ARB_RR_EN: alternation over 4 packets.
- Three i_pat_valid pulses while a message is in flight -> o_pat_drop_cnt=2, only the last pattern word transmitted.
- No i_ser_done for 255 cycles -> o_ser_timeout pulse, msg_full cleared, no o_msg_done; arbiter resumes.
- i_rst_n low during WAIT_DATA -> all outputs 0 next cycle; no o_msg_done; o_msg_ready=1 after release.
